wb_memory_slave: RTL and testbench
==================================

WB_MEMORY_SLAVE -- requirements
Module: wb_memory_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-003 SHALL have parameter LATENCY, default 1, range 0..15, meaning the wait cycles inserted before the response.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port wb_cyc  input  1  bus cycle active.
REQ-007 SHALL have port wb_stb  input  1  strobe, request valid.
REQ-008 SHALL have port wb_adr  input  32  byte address.
REQ-009 SHALL have port wb_sel  input  4  byte-lane select; bit i selects bits 8i+7:8i.
REQ-010 SHALL have port wb_we  input  1  1 = write, 0 = read.
REQ-011 SHALL have port wb_dat_mosi  input  32  write data.
REQ-012 SHALL have port wb_ack  output  1  successful completion, one-cycle pulse.
REQ-013 SHALL have port wb_err  output  1  error completion, one-cycle pulse.
REQ-014 SHALL have port wb_dat_miso  output  32  read data.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP; all outputs SHALL be registered.
REQ-016 In IDLE, wb_cyc&wb_stb high at a rising edge SHALL capture adr/sel/we/dat_mosi and go to WAIT if LATENCY>0, else to RESP.
REQ-017 WAIT SHALL count LATENCY cycles with a 4-bit counter, then go to RESP; the response SHALL appear exactly LATENCY+1 cycles after the accepting edge.
REQ-018 RESP SHALL assert exactly one of wb_ack/wb_err for exactly one cycle, then return to IDLE.
REQ-019 A request held high through the response cycle SHALL be re-sampled in IDLE; back-to-back accesses are therefore spaced LATENCY+2 cycles apart.
REQ-020 An error SHALL occur when the captured address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) or adr[1:0]!=0.
REQ-021 A read with ack SHALL drive wb_dat_miso with the full addressed word during the ack cycle, irrespective of wb_sel.
REQ-022 A write SHALL update only the lanes selected by sel, and SHALL be committed only in the ack cycle.
REQ-023 An errored access SHALL not modify memory, and wb_dat_miso SHALL be 0 during the err cycle.
REQ-024 wb_dat_miso SHALL be 0 in every cycle without wb_ack.
REQ-025 If wb_cyc drops while in WAIT, or at the edge entering RESP, the slave SHALL abort to IDLE with no ack, no err and no write.
REQ-026 wb_stb without wb_cyc SHALL be ignored.
REQ-027 A write with sel=4'b0000 SHALL ack and leave memory unchanged.

Reset
REQ-028 rst high at a rising edge SHALL force the state to IDLE, the counter to 0, wb_ack=0, wb_err=0 and wb_dat_miso=0, and SHALL drop any pending transaction.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-031 Bench SHALL cover: LATENCY=1, write adr 0x10, data 0xDEADBEEF, sel 4'hF, then read 0x10 -> ack 2 cycles after each accept; read returns 0xDEADBEEF.
REQ-032 Bench SHALL cover: write 0x11223344 to 0x20, write 0xAABBCCDD to 0x20 with sel 4'b0101, then read 0x20 -> 0x11BB33DD.
REQ-033 Bench SHALL cover: read adr 0x1002 (misaligned), then read adr 0x0000_1000 with DEPTH_WORDS=1024 -> wb_err pulse, no ack, miso 0, memory unchanged, for each.
REQ-034 Bench SHALL cover: LATENCY=3, write to 0x40 with cyc dropped 2 cycles after accept -> no ack or err, and a later read of 0x40 returns the old value.
REQ-035 Bench SHALL cover: rst asserted during WAIT of a write -> outputs 0 the next cycle, no ack, word unchanged, and the next request is served normally.
REQ-036 Bench SHALL cover: LATENCY=0 with stb held high for 3 consecutive reads -> an ack every 2nd cycle, each with correct data.

Source files
------------

// File: rtl/wb_memory_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_memory_slave                                            |
// | Description : Wishbone classic single-access memory slave with a         |
// |               configurable response latency, byte-lane writes and        |
// |               error completion for misaligned / out-of-window addresses. |
// | Ports       : clk         - system clock, rising edge                    |
// |               rst         - synchronous active-high reset                |
// |               wb_cyc      - bus cycle active                             |
// |               wb_stb      - request strobe                               |
// |               wb_adr      - byte address                                 |
// |               wb_sel      - byte-lane select (bit i -> bits 8i+7:8i)     |
// |               wb_we       - 1 = write, 0 = read                          |
// |               wb_dat_mosi - write data                                   |
// |               wb_ack      - successful completion pulse                  |
// |               wb_err      - error completion pulse                       |
// |               wb_dat_miso - read data, zero outside the ack cycle        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wb_memory_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic [31:0] wb_dat_mosi,
  output logic        wb_ack,
  output logic        wb_err,
  output logic [31:0] wb_dat_miso
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Counter value on which WAIT hands over to RESP (unused when LATENCY=0).
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] adr_q,   adr_d;
  logic [3:0]  sel_q,   sel_d;
  logic        we_q,    we_d;
  logic [31:0] dat_q,   dat_d;
  logic        ack_q,   ack_d;
  logic        err_q,   err_d;
  logic [31:0] miso_q,  miso_d;

  logic          w_bad;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd_word;

  // BASE_ADDR is aligned to the window size, so the window check reduces to
  // comparing the address bits above the word index.
  assign w_bad = (adr_q[1:0] != 2'b00) ||
                 (adr_q[31:AW+2] != BASE_ADDR[31:AW+2]);
  assign w_idx = adr_q[AW+1:2];

  // Writes land on the same edge that raises wb_ack; an abort (cyc low) or a
  // reset on that edge suppresses both.
  assign w_commit = (state_q == RESP) && wb_cyc && !w_bad && we_q && !rst;

  // One byte-wide array per lane keeps each lane's write port independent.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (w_commit && sel_q[i]) begin
        mem_q[w_idx] <= dat_q[8*i +: 8];
      end
    end

    assign w_rd_word[8*i +: 8] = mem_q[w_idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    miso_d  = 32'h0;

    case (state_q)
      IDLE: begin
        if (wb_cyc && wb_stb) begin
          adr_d   = wb_adr;
          sel_d   = wb_sel;
          we_d    = wb_we;
          dat_d   = wb_dat_mosi;
          cnt_d   = 4'd0;
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!wb_cyc) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (wb_cyc) begin
          if (w_bad) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (!we_q) begin
              miso_d = w_rd_word;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      dat_q   <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      miso_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      miso_q  <= miso_d;
    end
  end

  assign wb_ack      = ack_q;
  assign wb_err      = err_q;
  assign wb_dat_miso = miso_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_memory_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_memory_slave                                         |
// | Description : Directed self-checking bench for wb_memory_slave; three    |
// |               instances with LATENCY = 1, 3 and 0 share clock and reset. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wb_memory_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] miso [3];

  int total = 0;
  int bad   = 0;

  // Results of the last xfer() call.
  int          r_lat;
  logic        r_ack, r_err, r_stray, r_extra;
  logic [31:0] r_dat;

  always #5 clk = ~clk;

  wb_memory_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_adr(adr),
    .wb_sel(sel), .wb_we(we), .wb_dat_mosi(dat), .wb_ack(ack[0]),
    .wb_err(err[0]), .wb_dat_miso(miso[0]));

  wb_memory_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_adr(adr),
    .wb_sel(sel), .wb_we(we), .wb_dat_mosi(dat), .wb_ack(ack[1]),
    .wb_err(err[1]), .wb_dat_miso(miso[1]));

  wb_memory_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[2]), .wb_stb(stb[2]), .wb_adr(adr),
    .wb_sel(sel), .wb_we(we), .wb_dat_mosi(dat), .wb_ack(ack[2]),
    .wb_err(err[2]), .wb_dat_miso(miso[2]));

  // Single access on instance k. Entered and left 1 ns after a rising edge.
  // r_lat = edges from the accepting edge to the response (-1 on timeout).
  task automatic xfer(input int k, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    logic done;
    done = 1'b0;
    r_lat = -1; r_ack = 1'b0; r_err = 1'b0; r_dat = 32'h0;
    r_stray = 1'b0; r_extra = 1'b0;
    cyc[k] = 1'b1; stb[k] = 1'b1; we = w; adr = a; sel = s; dat = d;
    @(posedge clk); #1;
    stb[k] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (!done) begin
        @(posedge clk); #1;
        if (ack[k] || err[k]) begin
          r_lat = n; r_ack = ack[k]; r_err = err[k]; r_dat = miso[k];
          done = 1'b1;
        end else if (miso[k] != 32'h0) begin
          r_stray = 1'b1;
        end
      end
    end
    cyc[k] = 1'b0;
    @(posedge clk); #1;
    r_extra = ack[k] | err[k] | (miso[k] != 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ack[k] !== 1'b0 || err[k] !== 1'b0 || miso[k] !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d ack=%b err=%b miso=%h expected 0/0/0",
                 k, ack[k], err[k], miso[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_rw();
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    total++;
    if (r_ack !== 1'b1 || r_err !== 1'b0 || r_lat !== 2 || r_stray || r_extra) begin
      bad++;
      $display("FAIL basic_write ack=%b err=%b lat=%0d stray=%b extra=%b expected 1/0/2/0/0",
               r_ack, r_err, r_lat, r_stray, r_extra);
    end
    xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
    total++;
    if (r_ack !== 1'b1 || r_lat !== 2 || r_stray || r_extra) begin
      bad++;
      $display("FAIL basic_read_timing ack=%b lat=%0d stray=%b extra=%b expected 1/2/0/0",
               r_ack, r_lat, r_stray, r_extra);
    end
    total++;
    if (r_dat !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_read_data got=%h expected=deadbeef", r_dat);
    end
  endtask

  task automatic test_byte_lanes();
    xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    xfer(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    xfer(0, 1'b0, 32'h20, 4'hF, 32'h0);
    total++;
    if (r_ack !== 1'b1 || r_dat !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL lane_merge ack=%b got=%h expected ack=1 data=11bb33dd", r_ack, r_dat);
    end
    // sel = 0 write acks but leaves the word alone
    xfer(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF);
    total++;
    if (r_ack !== 1'b1 || r_err !== 1'b0) begin
      bad++;
      $display("FAIL sel0_write_ack ack=%b err=%b expected 1/0", r_ack, r_err);
    end
    xfer(0, 1'b0, 32'h20, 4'hF, 32'h0);
    total++;
    if (r_dat !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL sel0_unchanged got=%h expected=11bb33dd", r_dat);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_1002;
    addrs[1] = 32'h0000_1000;
    for (int i = 0; i < 2; i++) begin
      xfer(0, 1'b0, addrs[i], 4'hF, 32'h0);
      total++;
      if (r_err !== 1'b1 || r_ack !== 1'b0 || r_dat !== 32'h0 || r_lat !== 2 || r_extra) begin
        bad++;
        $display("FAIL err_read adr=%h err=%b ack=%b miso=%h lat=%0d extra=%b expected 1/0/0/2/0",
                 addrs[i], r_err, r_ack, r_dat, r_lat, r_extra);
      end
    end
    // Misaligned write inside the window and an aliasing write one window up
    xfer(0, 1'b1, 32'h12, 4'hF, 32'h0);
    total++;
    if (r_err !== 1'b1 || r_ack !== 1'b0) begin
      bad++;
      $display("FAIL err_write_misaligned err=%b ack=%b expected 1/0", r_err, r_ack);
    end
    xfer(0, 1'b1, 32'h1010, 4'hF, 32'h0);
    total++;
    if (r_err !== 1'b1 || r_ack !== 1'b0) begin
      bad++;
      $display("FAIL err_write_range err=%b ack=%b expected 1/0", r_err, r_ack);
    end
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0);
    total++;
    if (r_ack !== 1'b1 || r_dat !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL err_no_modify ack=%b got=%h expected ack=1 data=deadbeef", r_ack, r_dat);
    end
  endtask

  task automatic test_stb_no_cyc();
    logic seen;
    seen = 1'b0;
    cyc[0] = 1'b0; stb[0] = 1'b1; we = 1'b0; adr = 32'h10;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack[0] || err[0] || miso[0] != 32'h0) seen = 1'b1;
    end
    stb[0] = 1'b0;
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL stb_without_cyc response_seen=%b expected 0", seen);
    end
  endtask

  task automatic test_abort();
    logic seen;
    xfer(1, 1'b1, 32'h40, 4'hF, 32'h55AA55AA);
    total++;
    if (r_ack !== 1'b1 || r_lat !== 4 || r_stray || r_extra) begin
      bad++;
      $display("FAIL lat3_write ack=%b lat=%0d stray=%b extra=%b expected 1/4/0/0",
               r_ack, r_lat, r_stray, r_extra);
    end
    seen = 1'b0;
    cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF; dat = 32'h12345678;
    @(posedge clk); #1;          // accepting edge
    stb[1] = 1'b0;
    @(posedge clk); #1;          // one edge in WAIT
    cyc[1] = 1'b0;               // low at the second edge after accept
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1] || err[1] || miso[1] != 32'h0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_response response_seen=%b expected 0", seen);
    end
    xfer(1, 1'b0, 32'h40, 4'hF, 32'h0);
    total++;
    if (r_ack !== 1'b1 || r_dat !== 32'h55AA55AA) begin
      bad++;
      $display("FAIL abort_no_write ack=%b got=%h expected ack=1 data=55aa55aa", r_ack, r_dat);
    end
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    xfer(1, 1'b1, 32'h44, 4'hF, 32'hA5A5A5A5);
    seen = 1'b0;
    cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 32'h44; sel = 4'hF; dat = 32'hFFFF0000;
    @(posedge clk); #1;          // accepting edge
    stb[1] = 1'b0;
    @(posedge clk); #1;          // in WAIT
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0 || miso[1] !== 32'h0) begin
      bad++;
      $display("FAIL rst_in_wait_outputs ack=%b err=%b miso=%h expected 0/0/0",
               ack[1], err[1], miso[1]);
    end
    rst = 1'b0;
    // cyc stays high: a slave that kept the dropped transaction would answer
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) seen = 1'b1;
    end
    cyc[1] = 1'b0;
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_drops_txn response_seen=%b expected 0", seen);
    end
    xfer(1, 1'b0, 32'h44, 4'hF, 32'h0);
    total++;
    if (r_ack !== 1'b1 || r_lat !== 4 || r_dat !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL rst_then_read ack=%b lat=%0d got=%h expected 1/4/a5a5a5a5",
               r_ack, r_lat, r_dat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h0101_0101;
    exp_w[1] = 32'h2020_2020;
    exp_w[2] = 32'hC3C3_3C3C;
    for (int i = 0; i < 3; i++) begin
      xfer(2, 1'b1, 32'h80 + 32'(4*i), 4'hF, exp_w[i]);
      total++;
      if (r_ack !== 1'b1 || r_lat !== 1 || r_extra) begin
        bad++;
        $display("FAIL lat0_write idx=%0d ack=%b lat=%0d extra=%b expected 1/1/0",
                 i, r_ack, r_lat, r_extra);
      end
    end
    cyc[2] = 1'b1; stb[2] = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h80;
    @(posedge clk); #1;          // first accept
    adr = 32'h84;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      total++;
      if (ack[2] !== ((n % 2) == 1)) begin
        bad++;
        $display("FAIL b2b_ack_pattern cycle=%0d ack=%b expected %b", n, ack[2], ((n % 2) == 1));
      end
      total++;
      if ((n % 2) == 1) begin
        if (miso[2] !== exp_w[(n-1)/2]) begin
          bad++;
          $display("FAIL b2b_data cycle=%0d got=%h expected=%h", n, miso[2], exp_w[(n-1)/2]);
        end
      end else if (miso[2] !== 32'h0) begin
        bad++;
        $display("FAIL b2b_idle_miso cycle=%0d got=%h expected=0", n, miso[2]);
      end
      if (n == 2) adr = 32'h88;
      if (n == 4) stb[2] = 1'b0;
    end
    cyc[2] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cyc = 3'b000; stb = 3'b000;
    adr = 32'h0; sel = 4'h0; we = 1'b0; dat = 32'h0;
    test_reset();
    test_basic_rw();
    test_byte_lanes();
    test_errors();
    test_stb_no_cyc();
    test_abort();
    test_reset_in_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
